// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock, fixed latency of XLEN edges from accept to done.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV    = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
  } op_e;

  state_e            r_state;
  op_e               r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_hi;     // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;     // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]   r_dvs;    // multiplicand / divisor magnitude
  logic [XLEN-1:0]   r_a;
  logic              r_neg;
  logic              r_neg_rem;
  logic              r_div0;
  logic              r_ovf;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  // Operand conditioning at accept time.
  op_e             w_op;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;

  assign w_op    = op_e'(funct3);
  assign w_a_sgn = a[XLEN-1] & (w_op == OP_MULH || w_op == OP_MULHSU ||
                                w_op == OP_DIV  || w_op == OP_REM);
  assign w_b_sgn = b[XLEN-1] & (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM);
  assign w_a_mag = w_a_sgn ? -a : a;
  assign w_b_mag = w_b_sgn ? -b : b;
  assign w_div0  = (b == '0);
  assign w_ovf   = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1) &&
                   (w_op == OP_DIV || w_op == OP_REM);

  // One iteration step plus final sign fix-up and special-case override.
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rsh;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_n;
  logic [XLEN-1:0]   w_lo_n;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : '0);
    w_rsh   = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_rsh >= {1'b0, r_dvs});
    w_hi_n  = w_sum[XLEN:1];
    w_lo_n  = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      w_hi_n = w_ge ? (w_rsh[XLEN-1:0] - r_dvs) : w_rsh[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end
    w_prod  = {w_hi_n, w_lo_n};
    w_prod  = r_neg ? -w_prod : w_prod;
    w_quo   = r_neg ? -w_lo_n : w_lo_n;
    w_rem   = r_neg_rem ? -w_hi_n : w_hi_n;
    w_final = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:           w_final = w_prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  w_final = r_div0 ? '1 : (r_ovf ? r_a : w_quo);
      OP_REM, OP_REMU:  w_final = r_div0 ? r_a : (r_ovf ? '0 : w_rem);
      default:          w_final = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dvs     <= '0;
      r_a       <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_state   <= S_CALC;
            r_op      <= w_op;
            r_cnt     <= '0;
            r_rd      <= rd_in;
            r_a       <= a;
            r_hi      <= '0;
            r_lo      <= funct3[2] ? w_a_mag : w_b_mag;
            r_dvs     <= funct3[2] ? w_b_mag : w_a_mag;
            r_neg     <= w_a_sgn ^ w_b_sgn;
            r_neg_rem <= w_a_sgn;
            r_div0    <= w_div0;
            r_ovf     <= w_ovf;
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_result <= w_final;
              r_rd_out <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic corner cases,
// fixed latency, ignored start, flush and asynchronous reset mid-operation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an op before a rising edge; afterwards scramble the inputs so
  // only the captured copy can produce the right answer.
  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = av; b = bv; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; a = ~av; b = bv + 32'd5; rd_in = ~rd;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    issue(f, av, bv, rd);
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'd32);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    @(posedge clk); #1;
    check({tag, " done_drop"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen_done;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    reset = 1'b0;

    // Multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);

    // Divide family
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF);
    run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14);
    run_op("remu",   3'b111, 32'd100,      32'd7,        5'd31, 32'd2);
    run_op("divu0",  3'b101, 32'h1234,     32'd0,        5'd1,  32'hFFFFFFFF);
    run_op("remu0",  3'b111, 32'h1234,     32'd0,        5'd2,  32'h1234);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h80000000);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd4,  32'd0);
    run_op("rd0",    3'b000, 32'd12,       32'd11,       5'd0,  32'd132);

    // start pulsed mid-CALC with different operands must be ignored
    issue(3'b000, 32'd7, 32'd3, 5'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7; rd_in = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("ign latency", 32'(n + 5), 32'd32);
    check("ign result", result, 32'd21);
    check("ign rd_out", 32'(rd_out), 32'd3);
    @(posedge clk); #1;
    check("ign idle", 32'(busy), 32'd0);

    // flush at cycle 10 of CALC: no done, busy low after that edge, outputs held
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("flush no_done", 32'(seen_done), 32'd0);
    check("flush result", result, 32'd21);
    check("flush rd_out", 32'(rd_out), 32'd3);

    // asynchronous reset between edges in CALC
    issue(3'b101, 32'h1234, 32'h10, 5'd4);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst result", result, 32'd0);
    check("arst rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
